// File: rtl/pc_update_unit_if.sv
// Fetch-stage PC bus: branch request, targets and flags in, current PC and return address out.
interface pc_update_unit_if;
  logic        AddrSrc;
  logic [15:0] InAddrImm;
  logic [15:0] InAddrReg;
  logic        branch;
  logic [2:0]  cond;
  logic        Z;
  logic        N;
  logic        V;
  logic [15:0] OutAddr;
  logic [15:0] PCSOut;

  modport master (
    output AddrSrc, InAddrImm, InAddrReg, branch, cond, Z, N, V,
    input  OutAddr, PCSOut
  );

  modport slave (
    input  AddrSrc, InAddrImm, InAddrReg, branch, cond, Z, N, V,
    output OutAddr, PCSOut
  );
endinterface

// File: rtl/pc_update_unit.sv
// Program counter with conditional branch to an immediate word target or a register byte target.
module pc_update_unit (
  input  logic             clk,
  input  logic             rst,
  pc_update_unit_if.slave  bus
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] pc_seq;
  logic [15:0] target;
  logic        cond_true;
  logic        take;
  logic        unused_imm_msb;

  // Immediate is a word address; its top bit falls off when converted to bytes.
  assign unused_imm_msb = bus.InAddrImm[15];

  always_comb begin
    cond_true = 1'b0;
    case (bus.cond)
      3'b000:  cond_true = ~bus.Z;
      3'b001:  cond_true = bus.Z;
      3'b010:  cond_true = ~bus.Z & ~bus.N;
      3'b011:  cond_true = bus.N;
      3'b100:  cond_true = bus.Z | ~bus.N;
      3'b101:  cond_true = bus.Z | bus.N;
      3'b110:  cond_true = bus.V;
      default: cond_true = 1'b1; // unconditional: flags never consulted
    endcase
  end

  always_comb begin
    pc_seq = pc_q + 16'd2;
    take   = bus.branch & cond_true;
    target = bus.AddrSrc ? {bus.InAddrImm[14:0], 1'b0} : bus.InAddrReg;
    pc_d   = take ? target : pc_seq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= 16'h0000;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.OutAddr = pc_q;
  assign bus.PCSOut  = pc_seq;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed-vector bench for pc_update_unit with hand-computed PC sequence.
module tb_pc_update_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pc_update_unit_if bus ();

  pc_update_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then check the new PC and return address.
  task automatic step(input string tag, input logic br, input logic [2:0] cc, input logic src,
                      input logic [15:0] imm, input logic [15:0] rg,
                      input logic z, input logic n, input logic v, input logic [15:0] exp_pc);
    bus.branch    = br;
    bus.cond      = cc;
    bus.AddrSrc   = src;
    bus.InAddrImm = imm;
    bus.InAddrReg = rg;
    bus.Z         = z;
    bus.N         = n;
    bus.V         = v;
    @(posedge clk);
    #1;
    check_eq(tag, bus.OutAddr, exp_pc);
    check_eq({tag, "_pcs"}, bus.PCSOut, exp_pc + 16'd2);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    bus.branch = 1'b0; bus.cond = 3'b000; bus.AddrSrc = 1'b0;
    bus.InAddrImm = 16'h0; bus.InAddrReg = 16'h0;
    bus.Z = 1'b0; bus.N = 1'b0; bus.V = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_eq("rst_async", bus.OutAddr, 16'h0000);
    check_eq("rst_pcs", bus.PCSOut, 16'h0002);
    @(posedge clk);
    #1;
    check_eq("rst_hold", bus.OutAddr, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    step("seq0",   1'b0, 3'b000, 1'b1, 16'd0,  16'h0, 1'b0, 1'b0, 1'b0, 16'd2);
    step("ne_nt",  1'b1, 3'b000, 1'b1, 16'd5,  16'h0, 1'b1, 1'b0, 1'b0, 16'd4);
    step("ne_t",   1'b1, 3'b000, 1'b1, 16'd5,  16'h0, 1'b0, 1'b0, 1'b0, 16'd10);
    step("eq_nt",  1'b1, 3'b001, 1'b1, 16'd10, 16'h0, 1'b0, 1'b0, 1'b0, 16'd12);
    step("eq_t",   1'b1, 3'b001, 1'b1, 16'd10, 16'h0, 1'b1, 1'b0, 1'b0, 16'd20);
    step("gt_nt",  1'b1, 3'b010, 1'b1, 16'd15, 16'h0, 1'b1, 1'b1, 1'b0, 16'd22);
    step("gt_t",   1'b1, 3'b010, 1'b1, 16'd15, 16'h0, 1'b0, 1'b0, 1'b0, 16'd30);
    step("lt_nt",  1'b1, 3'b011, 1'b1, 16'd20, 16'h0, 1'b0, 1'b0, 1'b0, 16'd32);
    step("lt_t",   1'b1, 3'b011, 1'b1, 16'd20, 16'h0, 1'b0, 1'b1, 1'b0, 16'd40);
    step("ge_nt",  1'b1, 3'b100, 1'b1, 16'd25, 16'h0, 1'b0, 1'b1, 1'b0, 16'd42);
    step("ge_t",   1'b1, 3'b100, 1'b1, 16'd25, 16'h0, 1'b0, 1'b0, 1'b0, 16'd50);
    step("ge_tz",  1'b1, 3'b100, 1'b1, 16'd30, 16'h0, 1'b1, 1'b1, 1'b0, 16'd60);
    step("le_nt",  1'b1, 3'b101, 1'b1, 16'd35, 16'h0, 1'b0, 1'b0, 1'b0, 16'd62);
    step("le_tz",  1'b1, 3'b101, 1'b1, 16'd35, 16'h0, 1'b1, 1'b0, 1'b0, 16'd70);
    step("le_tn",  1'b1, 3'b101, 1'b1, 16'd40, 16'h0, 1'b0, 1'b1, 1'b0, 16'd80);
    step("ov_nt",  1'b1, 3'b110, 1'b1, 16'd45, 16'h0, 1'b0, 1'b0, 1'b0, 16'd82);
    step("ov_t",   1'b1, 3'b110, 1'b1, 16'd45, 16'h0, 1'b0, 1'b0, 1'b1, 16'd90);
    step("al_x",   1'b1, 3'b111, 1'b1, 16'd50, 16'h0, 1'bx, 1'bx, 1'bx, 16'd100);
    step("reg_t",  1'b1, 3'b111, 1'b0, 16'd0,  16'h1234, 1'b0, 1'b0, 1'b0, 16'h1234);
    step("reg_ff", 1'b1, 3'b111, 1'b0, 16'd0,  16'hFFFE, 1'b0, 1'b0, 1'b0, 16'hFFFE);
    step("wrap",   1'b0, 3'b000, 1'b0, 16'd0,  16'h0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step("imm_msb", 1'b1, 3'b111, 1'b1, 16'h8003, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0006);
    // Taken condition with branch low must still go sequential.
    step("nobr",   1'b0, 3'b111, 1'b1, 16'd7, 16'h5555, 1'b1, 1'b1, 1'b1, 16'h0008);

    // Reset mid-cycle with a taken branch pending.
    bus.branch = 1'b1; bus.cond = 3'b111; bus.AddrSrc = 1'b1; bus.InAddrImm = 16'd99;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid", bus.OutAddr, 16'h0000);
    check_eq("rst_mid_pcs", bus.PCSOut, 16'h0002);
    @(posedge clk);
    #1;
    check_eq("rst_mid_hold", bus.OutAddr, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
